// File: rtl/cpu_mem_responder.sv
// Memory-side responder: fixed-latency valid/ready word access to an on-chip RAM.
// Illegal requests skip the wait and answer with an error pulse.
module cpu_mem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_mem_req,
    input  logic        cpu_mem_read,
    input  logic        cpu_mem_write,
    input  logic [31:0] cpu_mem_addr,
    input  logic [31:0] cpu_mem_wdata,
    output logic        cpu_mem_ready,
    output logic        cpu_mem_rvalid,
    output logic [31:0] cpu_mem_rdata,
    output logic        cpu_mem_err
);

    localparam int CW    = $clog2(LATENCY + 1);
    localparam int DEPTH = 2 ** DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    wr_q, wr_d;
    logic                    err_q, err_d;
    logic [31:0]             rdata_q, rdata_d;

    logic [31:0]             mem [DEPTH];

    logic                    accept;
    logic                    illegal;
    logic                    commit;
    logic                    mem_we;

    assign accept = cpu_mem_req && (state_q == IDLE);

    always_comb begin
        illegal = 1'b0;
        if (cpu_mem_addr[1:0] != 2'b00)
            illegal = 1'b1;
        if (cpu_mem_addr[31:DEPTH_LOG2+2] != '0)
            illegal = 1'b1;
        if (cpu_mem_read == cpu_mem_write)
            illegal = 1'b1;
    end

    // The access happens on the edge that leaves WAIT, so RESP sees committed data.
    assign commit = (state_q == WAIT) && (cnt_q == '0);
    assign mem_we = commit && wr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[idx_q] <= wdata_q;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (cpu_mem_req)
                    state_d = illegal ? RESP : WAIT;
            end
            WAIT: begin
                if (cnt_q == '0)
                    state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        if (accept) begin
            cnt_d   = CW'(LATENCY - 1);
            idx_d   = cpu_mem_addr[DEPTH_LOG2+1:2];
            wdata_d = cpu_mem_wdata;
            wr_d    = cpu_mem_write;
            err_d   = illegal;
        end else if ((state_q == WAIT) && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
        if (commit && !wr_q)
            rdata_d = mem[idx_q];
    end

    always_comb begin
        cpu_mem_ready  = (state_q == IDLE);
        cpu_mem_rvalid = (state_q == RESP);
        cpu_mem_err    = (state_q == RESP) && err_q;
        cpu_mem_rdata  = rdata_q;
    end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder (DEPTH_LOG2=10, LATENCY=2).
// Each scenario task drives its own stimulus and checks inline.
module tb_cpu_mem_responder;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    int checks;
    int errors;

    cpu_mem_responder #(
        .DEPTH_LOG2(10),
        .LATENCY   (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cpu_mem_req   (req),
        .cpu_mem_read  (rd),
        .cpu_mem_write (wr),
        .cpu_mem_addr  (addr),
        .cpu_mem_wdata (wdata),
        .cpu_mem_ready (ready),
        .cpu_mem_rvalid(rvalid),
        .cpu_mem_rdata (rdata),
        .cpu_mem_err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request until accepted, then scrambles the inputs and
    // waits for the response. lat = sample index (1 = first cycle after
    // the accepting edge) at which rvalid was seen, -1 on timeout.
    task automatic issue(input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d,
                         output int lat, output int busy,
                         output logic e, output logic [31:0] q);
        bit acc;
        acc  = 0;
        lat  = -1;
        busy = 0;
        e    = 1'bx;
        q    = 'x;
        req   = 1'b1;
        rd    = r;
        wr    = w;
        addr  = a;
        wdata = d;
        for (int k = 0; k < 20 && !acc; k++) begin
            if (ready) acc = 1;
            step();
        end
        req   = 1'b0;
        rd    = ~r;
        wr    = ~w;
        addr  = ~a;
        wdata = ~d;
        if (acc) begin
            for (int k = 1; k <= 20; k++) begin
                if (!ready) busy++;
                if (rvalid) begin
                    lat = k;
                    e   = err;
                    q   = rdata;
                    break;
                end
                step();
            end
        end
    endtask

    task automatic test_reset();
        req = 0; rd = 0; wr = 0; addr = 0; wdata = 0;
        rst_n = 1'b0;
        #23;
        checks++;
        if (ready !== 1'b1 || rvalid !== 1'b0 || err !== 1'b0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: ready=%b rvalid=%b err=%b rdata=%h want 1 0 0 0",
                     ready, rvalid, err, rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset_abort();
        int lat, busy;
        logic e;
        logic [31:0] q;
        issue(0, 1, 32'h10, 32'h11111111, lat, busy, e, q);
        step();
        req = 1; rd = 0; wr = 1; addr = 32'h10; wdata = 32'hDEADBEEF;
        while (!ready) step();
        step();
        req = 0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b1 || rvalid !== 1'b0 || err !== 1'b0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL abort_outputs: ready=%b rvalid=%b err=%b rdata=%h want 1 0 0 0",
                     ready, rvalid, err, rdata);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (rvalid !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_no_rvalid: rvalid=%b ready=%b want 0 1", rvalid, ready);
        end
        step();
        issue(1, 0, 32'h10, 32'h0, lat, busy, e, q);
        checks++;
        if (q !== 32'h11111111 || e !== 1'b0) begin
            errors++;
            $display("FAIL abort_readback: rdata=%h err=%b want 11111111 0", q, e);
        end
        step();
    endtask

    task automatic test_write_read();
        int lat, busy;
        logic e;
        logic [31:0] q;
        issue(0, 1, 32'h40, 32'hCAFEF00D, lat, busy, e, q);
        checks++;
        if (lat !== 3 || busy !== 3 || e !== 1'b0) begin
            errors++;
            $display("FAIL write_latency: lat=%0d busy=%0d err=%b want 3 3 0", lat, busy, e);
        end
        step();
        checks++;
        if (rvalid !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL write_pulse_end: rvalid=%b ready=%b want 0 1", rvalid, ready);
        end
        issue(1, 0, 32'h40, 32'h0, lat, busy, e, q);
        checks++;
        if (lat !== 3 || q !== 32'hCAFEF00D || e !== 1'b0) begin
            errors++;
            $display("FAIL read_back: lat=%0d rdata=%h err=%b want 3 cafef00d 0", lat, q, e);
        end
        step();
    endtask

    task automatic test_misaligned();
        int lat, busy;
        logic e;
        logic [31:0] q;
        issue(1, 0, 32'h42, 32'h0, lat, busy, e, q);
        checks++;
        if (lat !== 1 || e !== 1'b1 || q !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL misaligned: lat=%0d err=%b rdata=%h want 1 1 cafef00d", lat, e, q);
        end
        step();
        checks++;
        if (ready !== 1'b1 || rvalid !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL misaligned_end: ready=%b rvalid=%b err=%b want 1 0 0", ready, rvalid, err);
        end
    endtask

    task automatic test_range();
        int lat, busy;
        logic e;
        logic [31:0] q;
        issue(1, 0, 32'h1000, 32'h0, lat, busy, e, q);
        checks++;
        if (lat !== 1 || e !== 1'b1) begin
            errors++;
            $display("FAIL out_of_range: lat=%0d err=%b want 1 1", lat, e);
        end
        step();
        issue(0, 1, 32'h0FFC, 32'h5A5A5A5A, lat, busy, e, q);
        checks++;
        if (lat !== 3 || e !== 1'b0) begin
            errors++;
            $display("FAIL top_write: lat=%0d err=%b want 3 0", lat, e);
        end
        step();
        issue(1, 0, 32'h0FFC, 32'h0, lat, busy, e, q);
        checks++;
        if (q !== 32'h5A5A5A5A || e !== 1'b0) begin
            errors++;
            $display("FAIL top_read: rdata=%h err=%b want 5a5a5a5a 0", q, e);
        end
        step();
    endtask

    task automatic test_bad_op();
        int lat, busy;
        logic e;
        logic [31:0] q;
        issue(0, 1, 32'h20, 32'h12345678, lat, busy, e, q);
        step();
        issue(1, 1, 32'h20, 32'h87654321, lat, busy, e, q);
        checks++;
        if (lat !== 1 || e !== 1'b1) begin
            errors++;
            $display("FAIL both_ops: lat=%0d err=%b want 1 1", lat, e);
        end
        step();
        issue(0, 0, 32'h20, 32'h87654321, lat, busy, e, q);
        checks++;
        if (lat !== 1 || e !== 1'b1) begin
            errors++;
            $display("FAIL no_op: lat=%0d err=%b want 1 1", lat, e);
        end
        step();
        issue(1, 0, 32'h20, 32'h0, lat, busy, e, q);
        checks++;
        if (q !== 32'h12345678 || e !== 1'b0) begin
            errors++;
            $display("FAIL bad_op_preserve: rdata=%h err=%b want 12345678 0", q, e);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int lat, busy;
        logic e;
        logic [31:0] q;
        logic [31:0] seen [8];
        logic        vseen [8];
        logic        rseen [8];
        issue(0, 1, 32'h0, 32'hA0A0A0A0, lat, busy, e, q);
        step();
        issue(0, 1, 32'h4, 32'hB1B1B1B1, lat, busy, e, q);
        step();
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_start_ready: ready=%b want 1", ready);
        end
        req = 1; rd = 1; wr = 0; addr = 32'h0; wdata = 32'h0;
        step();
        for (int t = 1; t <= 7; t++) begin
            vseen[t] = rvalid;
            rseen[t] = ready;
            seen[t]  = rdata;
            if (t == 1) begin
                rd = 0; wr = 1; addr = 32'h4; wdata = 32'hFFFFFFFF;
            end
            if (t == 3) begin
                rd = 1; wr = 0; addr = 32'h4; wdata = 32'h0;
            end
            if (t == 5) begin
                rd = 0; wr = 1; addr = 32'h0; wdata = 32'h0;
            end
            step();
        end
        req = 0;
        checks++;
        if (vseen[3] !== 1'b1 || seen[3] !== 32'hA0A0A0A0) begin
            errors++;
            $display("FAIL b2b_first: rvalid=%b rdata=%h want 1 a0a0a0a0", vseen[3], seen[3]);
        end
        checks++;
        if (rseen[4] !== 1'b1 || rseen[5] !== 1'b0 || vseen[4] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: ready4=%b ready5=%b rvalid4=%b want 1 0 0",
                     rseen[4], rseen[5], vseen[4]);
        end
        checks++;
        if (vseen[7] !== 1'b1 || seen[7] !== 32'hB1B1B1B1 || vseen[6] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: rvalid7=%b rdata=%h rvalid6=%b want 1 b1b1b1b1 0",
                     vseen[7], seen[7], vseen[6]);
        end
        step();
        issue(1, 0, 32'h4, 32'h0, lat, busy, e, q);
        checks++;
        if (q !== 32'hB1B1B1B1) begin
            errors++;
            $display("FAIL b2b_no_write: rdata=%h want b1b1b1b1", q);
        end
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_reset_abort();
        test_write_read();
        test_misaligned();
        test_range();
        test_bad_op();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
